// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//   Pipeline hazard detection and operand forwarding for an in-order core.
//   Tracks destination info for DEPTH post-ID stages (1=EXE, 2=MEM, 3=WB).
//   For each ID source operand it picks the youngest matching producer. When
//   that producer's result is ready, the unit forwards it. When the producer
//   is a load that has not yet reached LOAD_STAGE, the unit stalls instead.
//
// Ports
//   Clock, Resetn            : clock, asynchronous active-low reset
//   id_valid                 : ID holds a real instruction
//   id_rs, id_rt             : ID source register numbers
//   id_use_rs, id_use_rt     : ID instruction actually reads that source
//   id_rd, id_wreg, id_m2reg : ID destination / writes reg / is a load
//   flush                    : squash the ID instruction this cycle
//   stage_data               : stage k result on [k*XLEN-1 : (k-1)*XLEN]
//   rf_a, rf_b               : register-file read values
//   op_a, op_b               : resolved operands (combinational)
//   fwd_sel_a, fwd_sel_b     : 0 = register file, k = forwarded from stage k
//   stall                    : hold IF/ID and insert a bubble
//   stall_count, fwd_count   : saturating performance counters
// -----------------------------------------------------------------------------

// Per-source resolver: finds the youngest hit among the tracked stages and
// selects either the forwarded stage result or the register-file value.
module hfu_src_resolve #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH:1]            v,
    input  logic [DEPTH:1]            wreg,
    input  logic [DEPTH:1]            m2reg,
    input  logic [DEPTH:1][AW-1:0]    rd,
    input  logic [DEPTH*XLEN-1:0]     stage_data,
    input  logic [AW-1:0]             src,
    input  logic                      use_src,
    input  logic [XLEN-1:0]           rf,
    output logic [XLEN-1:0]           op,
    output logic [SW-1:0]             sel,
    output logic                      not_ready
);

    logic            hit;
    logic [SW-1:0]   hit_k;
    logic            hit_load;
    logic [XLEN-1:0] hit_data;

    // Scan from oldest to youngest so the youngest (smallest k) match is the
    // last assignment and therefore wins. Register 0 never matches.
    always_comb begin
        hit      = 1'b0;
        hit_k    = '0;
        hit_load = 1'b0;
        hit_data = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (v[k] && wreg[k] && (rd[k] == src) && (src != '0) && use_src) begin
                hit      = 1'b1;
                hit_k    = SW'(k);
                hit_load = m2reg[k] && (k < LOAD_STAGE);
                hit_data = stage_data[(k-1)*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        not_ready = hit && hit_load;
        if (hit && !hit_load) begin
            sel = hit_k;
            op  = hit_data;
        end else begin
            sel = '0;
            op  = rf;
        end
    end

endmodule

module hazard_fwd_unit #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  id_valid,
    input  logic [AW-1:0]         id_rs,
    input  logic [AW-1:0]         id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [AW-1:0]         id_rd,
    input  logic                  id_wreg,
    input  logic                  id_m2reg,
    input  logic                  flush,
    input  logic [DEPTH*XLEN-1:0] stage_data,
    input  logic [XLEN-1:0]       rf_a,
    input  logic [XLEN-1:0]       rf_b,
    output logic [XLEN-1:0]       op_a,
    output logic [XLEN-1:0]       op_b,
    output logic [SW-1:0]         fwd_sel_a,
    output logic [SW-1:0]         fwd_sel_b,
    output logic                  stall,
    output logic [15:0]           stall_count,
    output logic [15:0]           fwd_count
);

    // Tracked producer info per post-ID stage, indexed 1..DEPTH
    logic [DEPTH:1]         v;
    logic [DEPTH:1]         wreg;
    logic [DEPTH:1]         m2reg;
    logic [DEPTH:1][AW-1:0] rd;

    logic nr_a, nr_b;
    logic id_live;
    logic issue;

    hfu_src_resolve #(
        .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SW(SW)
    ) u_res_a (
        .v          (v),
        .wreg       (wreg),
        .m2reg      (m2reg),
        .rd         (rd),
        .stage_data (stage_data),
        .src        (id_rs),
        .use_src    (id_use_rs),
        .rf         (rf_a),
        .op         (op_a),
        .sel        (fwd_sel_a),
        .not_ready  (nr_a)
    );

    hfu_src_resolve #(
        .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SW(SW)
    ) u_res_b (
        .v          (v),
        .wreg       (wreg),
        .m2reg      (m2reg),
        .rd         (rd),
        .stage_data (stage_data),
        .src        (id_rt),
        .use_src    (id_use_rt),
        .rf         (rf_b),
        .op         (op_b),
        .sel        (fwd_sel_b),
        .not_ready  (nr_b)
    );

    // A flushed ID instruction is dead: it neither stalls nor issues.
    assign id_live = id_valid && !flush;
    assign stall   = id_live && (nr_a || nr_b);
    assign issue   = id_live && !stall;

    // Stages keep advancing during a stall; stage 1 receives a bubble so the
    // held ID instruction re-evaluates against the moved-on producers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            v     <= '0;
            wreg  <= '0;
            m2reg <= '0;
            rd    <= '0;
        end else begin
            v[1]     <= issue;
            wreg[1]  <= id_wreg;
            m2reg[1] <= id_m2reg;
            rd[1]    <= id_rd;
            for (int k = 2; k <= DEPTH; k++) begin
                v[k]     <= v[k-1];
                wreg[k]  <= wreg[k-1];
                m2reg[k] <= m2reg[k-1];
                rd[k]    <= rd[k-1];
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
            if (issue && ((fwd_sel_a != '0) || (fwd_sel_b != '0)) &&
                (fwd_count != 16'hFFFF))
                fwd_count <= fwd_count + 16'd1;
        end
    end

endmodule
